serial_subtractor: RTL

- Bit-serial two's-complement subtractor, computing Diff = A - B over WIDTH clock cycles with a single full-adder cell and a registered borrow chain.
- It is the sequential, inverse-operation counterpart to the combinational ripple adders in the arithmetic library.
- Used where area matters more than latency; a start/busy/done handshake connects it to a controlling FSM.

---
 rtl/serial_subtractor.sv | 74 +++++++
 1 files changed

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial A - B over WIDTH cycles; define SERIAL_SUB_OVF_EN to add the Ovf output
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Diff,
`ifdef SERIAL_SUB_OVF_EN
    output logic             Bout,
    output logic             Ovf
`else
    output logic             Bout
`endif
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
    logic [1:0] state;
    logic [WIDTH-1:0] a_sr, b_sr, res;
    logic [CW-1:0] cnt;
    logic c, nb, s, c_nx, last, accept;
    assign busy = state == RUN;
    assign done = state == DONE;
    // one full-adder cell computing a + ~b + carry, carry seeded with 1
    always_comb begin
        nb = ~b_sr[0];
        s = a_sr[0] ^ nb ^ c;
        c_nx = (a_sr[0] & nb) | (a_sr[0] & c) | (nb & c);
        last = cnt == CW'(WIDTH - 1);
        accept = start && state != RUN;
    end
    // control FSM, operand shifting and result capture on the final bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            a_sr <= '0;
            b_sr <= '0;
            res <= '0;
            cnt <= '0;
            c <= 1'b0;
            Diff <= '0;
            Bout <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            Ovf <= 1'b0;
`endif
        end else if (accept) begin
            state <= RUN;
            a_sr <= A;
            b_sr <= B;
            cnt <= '0;
            c <= 1'b1;
        end else if (state == RUN) begin
            a_sr <= a_sr >> 1;
            b_sr <= b_sr >> 1;
            res <= {s, res[WIDTH-1:1]};
            c <= c_nx;
            cnt <= cnt + 1'b1;
            if (last) begin
                state <= DONE;
                Diff <= {s, res[WIDTH-1:1]};
                Bout <= ~c_nx;
`ifdef SERIAL_SUB_OVF_EN
                Ovf <= c ^ c_nx;
`endif
            end
        end else begin
            state <= IDLE;
        end
    end
endmodule
